// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and fetch FSM encoding
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [5:0]  OP_COP1   = 6'h11;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

    // Register specifier tagged with a COP1 bit so FP and integer registers never alias
    function automatic logic [5:0] reg_spec(input logic [31:0] instr, input logic [4:0] field);
        return {instr[31:26] == OP_COP1, field};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with enable, flush and valid bit
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (enable) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= valid_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, fetch request FSM and IF/ID loading
module fetch_stage
    import fetch_stage_pkg::fetch_state_t;
    import fetch_stage_pkg::ST_REQ;
    import fetch_stage_pkg::ST_HOLD;
    import fetch_stage_pkg::reg_spec;
#(
    parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid,
    output logic [5:0]  IF_ID_RS,
    output logic [5:0]  IF_ID_RT
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4;
    logic [31:0]  buffer, buffer_next;
    logic         id_enable;
    logic [31:0]  id_instr;
    logic         id_valid;
    logic         word_loaded;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = (state == ST_REQ) && !reset;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        buffer_next = buffer;
        id_enable   = 1'b0;
        id_instr    = NOP_INSTR;
        id_valid    = 1'b0;
        word_loaded = 1'b0;
        if (branch_taken) begin
            // Redirect wins over stalls and acks; the parked word belongs to the wrong path
            state_next  = ST_REQ;
            pc_next     = {branch_target[31:2], 2'b00};
            buffer_next = 32'h0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (IF_ID_Write) begin
                        id_enable   = 1'b1;
                        id_instr    = imem_ack ? imem_rdata : NOP_INSTR;
                        id_valid    = imem_ack;
                        word_loaded = imem_ack;
                    end else if (imem_ack) begin
                        buffer_next = imem_rdata;
                        state_next  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (IF_ID_Write) begin
                        id_enable   = 1'b1;
                        id_instr    = buffer;
                        id_valid    = 1'b1;
                        word_loaded = 1'b1;
                        state_next  = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
            if (word_loaded && PC_Write) begin
                pc_next = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            buffer <= 32'h0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            buffer <= buffer_next;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .rst         (reset),
        .enable      (id_enable),
        .flush       (branch_taken),
        .instr_in    (id_instr),
        .pc_plus4_in (pc_plus4),
        .valid_in    (id_valid),
        .instr       (IF_ID_instr),
        .pc_plus4    (IF_ID_PC_plus4),
        .valid       (IF_ID_valid)
    );

    assign IF_ID_RS = reg_spec(IF_ID_instr, IF_ID_instr[25:21]);
    assign IF_ID_RT = reg_spec(IF_ID_instr, IF_ID_instr[20:16]);

endmodule
